// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//
// Collects completed results from the functional units and drives the common
// data bus. Each unit hands one result over a valid/ready handshake into a
// private one-entry holding register; every cycle up to CDB_COUNT held results
// are granted in round-robin order and broadcast from registered CDB ports.
//
// Ports:
//   clk        - single clock, all state updates on the rising edge
//   rst        - asynchronous, active-low reset
//   flush      - synchronous pipeline flush (drops held results and grants)
//   fu_valid   - per unit: a result is presented
//   fu_result  - per unit: result payload (its ready field is ignored)
//   fu_ready   - per unit: the arbiter accepts the presented result this cycle
//   cdb        - registered broadcast ports; .ready=1 marks a valid slot
// -----------------------------------------------------------------------------
package cdb_pkg;
  typedef struct packed {
    logic        ready;
    logic [4:0]  pr_dest;
    logic [31:0] result;
  } cdb_t;
endpackage

module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int FU_COUNT  = 4,
  parameter int CDB_COUNT = 1,
  parameter int PR_BITS   = 5   // must equal the pr_dest width of cdb_t
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic fu_valid  [FU_COUNT],
  input  cdb_t fu_result [FU_COUNT],
  output logic fu_ready  [FU_COUNT],
  output cdb_t cdb       [CDB_COUNT]
);

  localparam int PTR_W = (FU_COUNT > 1) ? $clog2(FU_COUNT) : 1;

  logic               hold_valid  [FU_COUNT];
  logic [PR_BITS-1:0] hold_dest   [FU_COUNT];
  logic [31:0]        hold_result [FU_COUNT];
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   rr_next;

  int                 off  [FU_COUNT];   // position of unit i in this cycle's scan
  int                 rank [FU_COUNT];   // held units scanned ahead of unit i
  logic               grant [FU_COUNT];

  logic               slot_valid  [CDB_COUNT];
  logic [PR_BITS-1:0] slot_dest   [CDB_COUNT];
  logic [31:0]        slot_result [CDB_COUNT];

  logic [FU_COUNT-1:0] unused_ready;

  // A unit is granted when fewer than CDB_COUNT held units precede it in the
  // scan starting at rr_ptr; its rank is then the CDB port it lands on.
  always_comb begin
    for (int i = 0; i < FU_COUNT; i++) begin
      off[i] = (i + FU_COUNT - int'(rr_ptr)) % FU_COUNT;
    end
    for (int i = 0; i < FU_COUNT; i++) begin
      rank[i] = 0;
      for (int j = 0; j < FU_COUNT; j++) begin
        if (hold_valid[j] && (off[j] < off[i])) begin
          rank[i] = rank[i] + 1;
        end
      end
      grant[i] = hold_valid[i] && (rank[i] < CDB_COUNT);
    end
  end

  always_comb begin
    for (int k = 0; k < CDB_COUNT; k++) begin
      slot_valid[k]  = 1'b0;
      slot_dest[k]   = '0;
      slot_result[k] = '0;
    end
    for (int k = 0; k < CDB_COUNT; k++) begin
      for (int i = 0; i < FU_COUNT; i++) begin
        if (grant[i] && (rank[i] == k)) begin
          slot_valid[k]  = 1'b1;
          slot_dest[k]   = hold_dest[i];
          slot_result[k] = hold_result[i];
        end
      end
    end
  end

  // Pointer moves just past the granted unit furthest along the scan; with no
  // grant it stays put.
  always_comb begin
    int last_off;
    last_off = -1;
    rr_next  = rr_ptr;
    for (int i = 0; i < FU_COUNT; i++) begin
      if (grant[i] && (off[i] > last_off)) begin
        last_off = off[i];
        rr_next  = PTR_W'((i + 1) % FU_COUNT);
      end
    end
  end

  // A granted entry drains this edge, so it can be refilled in the same cycle.
  for (genvar gi = 0; gi < FU_COUNT; gi++) begin : g_unit
    assign fu_ready[gi]     = !flush && (!hold_valid[gi] || grant[gi]);
    // The incoming ready flag has no meaning on the producer side.
    assign unused_ready[gi] = fu_result[gi].ready;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FU_COUNT; i++) begin
        hold_valid[i]  <= 1'b0;
        hold_dest[i]   <= '0;
        hold_result[i] <= '0;
      end
    end else begin
      for (int i = 0; i < FU_COUNT; i++) begin
        if (flush) begin
          hold_valid[i] <= 1'b0;
        end else if (fu_valid[i] && fu_ready[i]) begin
          hold_valid[i]  <= 1'b1;
          hold_dest[i]   <= fu_result[i].pr_dest;
          hold_result[i] <= fu_result[i].result;
        end else if (grant[i]) begin
          hold_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
      for (int k = 0; k < CDB_COUNT; k++) cdb[k] <= '0;
    end else if (flush) begin
      rr_ptr <= '0;
      for (int k = 0; k < CDB_COUNT; k++) cdb[k] <= '0;
    end else begin
      rr_ptr <= rr_next;
      for (int k = 0; k < CDB_COUNT; k++) begin
        cdb[k].ready   <= slot_valid[k];
        cdb[k].pr_dest <= slot_dest[k];
        cdb[k].result  <= slot_result[k];
      end
    end
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Collects completed results from the functional units and drives the common data bus (`cdb_t`) consumed by the physical register file, reservation stations and ROB. Each functional unit hands over one result through a valid/ready handshake into a private one-entry holding register. Every cycle up to `CDB_COUNT` held results are granted in round-robin order and broadcast from registered CDB ports.

## Interface
- `FU_COUNT`, 4: number of producing functional units, ≥ 1.
- `CDB_COUNT`, 1: number of CDB broadcast ports, 1 ≤ `CDB_COUNT` ≤ `FU_COUNT`.
- `PR_BITS`, 5: physical register index width; must match the `pr_dest` width in `cdb_t`.

Ports:
- `clk` input 1: single clock; all state is updated on its rising edge.
- `rst` input 1: reset, asynchronous, active-low (asserted when 0).
- `flush` input 1: synchronous pipeline flush (mispredict).
- `fu_valid[FU_COUNT]` input 1 each: unit i presents a result.
- `fu_result[FU_COUNT]` input `cdb_t` each: result payload; the `ready` field is ignored.
- `fu_ready[FU_COUNT]` output 1 each: arbiter accepts unit i's result this cycle.
- `cdb[CDB_COUNT]` output `cdb_t` each: registered broadcast; `.ready`=1 marks a valid slot.

## Operation
- **State:**
  - `hold_valid[i]` and `hold_data[i]` per unit.
  - `rr_ptr`, width clog2(`FU_COUNT`), minimum 1 bit.
  - Output registers `cdb[k]`.
- **Grant:** scan the units i = `rr_ptr`, `rr_ptr`+1, …, wrapping modulo `FU_COUNT`. The first `CDB_COUNT` units with `hold_valid` set are granted. The j-th granted unit goes to `cdb[j]`, in scan order.
- **Unused CDB ports:** a port with no grant loads `.ready`=0. Its `pr_dest` and `result` load 0.
- **Pointer update:** if any unit is granted, `rr_ptr` becomes (last granted index + 1) mod `FU_COUNT`. If none is granted, `rr_ptr` is unchanged.
- **Acceptance:**
  - `fu_ready[i]` = !`flush` && (!`hold_valid[i]` || grant[i]). A granted entry may be refilled in the same cycle.
  - `fu_ready` is combinational from state and `flush` only. It never depends on `fu_valid`.
  - A transfer happens when `fu_valid[i]` && `fu_ready[i]`. At that edge `hold_data[i]` ← `fu_result[i]` and `hold_valid[i]` ← 1.
- **Release:** if unit i is granted and no new transfer occurs, `hold_valid[i]` ← 0.
- **Payload:** `fu_result` fields other than `ready` are copied unmodified.
- **Destination p0:** results with `pr_dest`=0 are still broadcast. The register file ignores them, but the ROB needs the completion.
- **Flush:**
  - At the edge, all `hold_valid` clear, every `cdb[k].ready` clears, and no transfer occurs.
  - `rr_ptr` is reset to 0.
  - Grants computed during a flush cycle are discarded.
- **Reset:** while `rst`=0, regardless of `clk`:
  - `hold_valid`=0, `rr_ptr`=0.
  - All `cdb[k]` fields are 0.
  - `fu_ready[i]`=1 whenever `flush`=0.
- **Reset mid-operation:** held results are lost. No partial CDB slot survives.
- **Ordering:** results from one unit are broadcast in acceptance order. There is no ordering guarantee across units.

## Timing
- **Latency:** a result accepted at edge E is held from E. If granted in the cycle after E, it is on `cdb` after edge E+1. Minimum latency from handshake to broadcast is 1 cycle.
- **Throughput:** one result per unit per cycle when that unit is granted every cycle. Aggregate throughput is `CDB_COUNT` results per cycle.
- **Starvation bound:** a held result waits at most ceil(`FU_COUNT`/`CDB_COUNT`)−1 cycles after its first grant-eligible cycle.
- **Single-cycle broadcast:** each `cdb` value is valid for exactly one cycle. A slot reloads every edge.
- **Full:** when `hold_valid[i]`=1 and unit i is not granted, `fu_ready[i]`=0. The unit must keep `fu_valid` and payload stable until `fu_ready` is 1.
- **Empty:** when all `hold_valid` are 0, the next edge loads every `cdb[k].ready`=0.
- **Simultaneous events:**
  - `flush` overrides grant, transfer and `rst`-released state at the same edge.
  - `rst` overrides everything asynchronously.

## Test plan
- **Reset:** drive `rst`=0 mid-cycle with entries held. Required response: `cdb[0].ready`=0 and `pr_dest`=0 immediately, with no clock edge. After release, `fu_ready`=1111.
- **Single result:** `FU_COUNT`=4, `CDB_COUNT`=1. Unit 2 presents `pr_dest`=7, `result`=0xDEADBEEF at edge 0. Required response: `cdb[0]` = {ready 1, pr_dest 7, result 0xDEADBEEF} after edge 1 for exactly one cycle; `rr_ptr`=3.
- **Round-robin fairness:** all 4 units hold results, `rr_ptr`=0, units keep refilling every cycle. Required response: broadcast order 0,1,2,3,0; each `fu_ready[i]`=1 only in its grant cycle.
- **Dual CDB:** `CDB_COUNT`=2 with units 1 and 3 held and `rr_ptr`=2. Required response: `cdb[0]` carries unit 3, `cdb[1]` carries unit 1, then `rr_ptr`=2.
- **Flush during back-pressure:** hold 3 results, assert `flush` together with `fu_valid[0]`=1. Required response: `fu_ready`=0000 that cycle; the next cycle `cdb[*].ready`=0, all holds empty, `rr_ptr`=0.
- **Destination p0:** unit 0 presents `pr_dest`=0, `result`=5. Required response: broadcast with `cdb[0].ready`=1, `pr_dest`=0, `result`=5.
